rr_mux_n_to_1: RTL and testbench



---
 rtl/rr_mux_n_to_1_if.sv | 38 +++
 rtl/rr_mux_n_to_1.sv | 75 +++++++
 tb/tb_rr_mux_n_to_1.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rr_mux_n_to_1_if.sv
// Handshake bundle between n producer channels, the round-robin mux, and one consumer.
// Channel i occupies inData[i*w +: w]; outSel carries the source index of outData.
interface rr_mux_n_to_1_if #(
    parameter int unsigned n = 4,
    parameter int unsigned w = 8
);
    localparam int unsigned logn = $clog2(n);

    logic [n*w-1:0]  inData;
    logic [n-1:0]    inValid;
    logic [n-1:0]    inReady;
    logic [w-1:0]    outData;
    logic [logn-1:0] outSel;
    logic            outValid;
    logic            outReady;

    // Environment side: drives the input channels and the downstream ready.
    modport master (
        output inData,
        output inValid,
        output outReady,
        input  inReady,
        input  outData,
        input  outSel,
        input  outValid
    );

    // Mux side.
    modport slave (
        input  inData,
        input  inValid,
        input  outReady,
        output inReady,
        output outData,
        output outSel,
        output outValid
    );
endinterface

// File: rtl/rr_mux_n_to_1.sv
// Round-robin n-to-1 handshaked mux with a single registered output stage.
// Each output beat is tagged with its source channel index for downstream demux.
module rr_mux_n_to_1 #(
    parameter int unsigned n = 4,
    parameter int unsigned w = 8
) (
    input logic             clk,
    input logic             rst,
    rr_mux_n_to_1_if.slave  bus
);
    localparam int unsigned logn = $clog2(n);
    localparam int unsigned iw   = logn + 1;

    logic [logn-1:0] ptr;
    logic [w-1:0]    data_q;
    logic [logn-1:0] sel_q;
    logic            valid_q;

    logic [logn-1:0] grant_c;
    logic [logn-1:0] ptr_next_c;
    logic [iw-1:0]   idx_c;
    logic            found_c;
    logic            any_valid_c;
    logic            load_c;

    // First valid channel at or after ptr, wrapping modulo n (n need not be a power of two).
    always_comb begin
        grant_c = ptr;
        found_c = 1'b0;
        idx_c   = '0;
        for (int unsigned k = 0; k < n; k++) begin
            idx_c = iw'(ptr) + iw'(k);
            if (idx_c >= iw'(n)) begin
                idx_c = idx_c - iw'(n);
            end
            if (!found_c && bus.inValid[idx_c[logn-1:0]]) begin
                found_c = 1'b1;
                grant_c = idx_c[logn-1:0];
            end
        end
    end

    assign any_valid_c = |bus.inValid;
    assign load_c      = (!valid_q || bus.outReady) && any_valid_c;
    assign ptr_next_c  = (grant_c == logn'(n - 1)) ? '0 : grant_c + logn'(1);

    assign bus.inReady  = (load_c && !rst) ? (n'(1) << grant_c) : '0;
    assign bus.outData  = data_q;
    assign bus.outSel   = sel_q;
    assign bus.outValid = valid_q;

    // Output stage: load overwrites a draining beat with no bubble; a stalled beat holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr     <= '0;
        end else if (load_c) begin
            data_q  <= bus.inData[32'(grant_c) * w +: w];
            sel_q   <= grant_c;
            valid_q <= 1'b1;
            ptr     <= ptr_next_c;
        end else if (valid_q && bus.outReady) begin
            valid_q <= 1'b0;
        end
    end

    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (valid_q && !bus.outReady) |=> (valid_q && $stable(data_q) && $stable(sel_q)));

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.inReady));

endmodule

// File: tb/tb_rr_mux_n_to_1.sv
// Directed bench for rr_mux_n_to_1: n=4 and n=3 instances sharing clock and reset.
module tb_rr_mux_n_to_1;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    rr_mux_n_to_1_if #(.n(4), .w(8)) b4 ();
    rr_mux_n_to_1_if #(.n(3), .w(8)) b3 ();

    rr_mux_n_to_1 #(.n(4), .w(8)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
    rr_mux_n_to_1 #(.n(3), .w(8)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] sat_data [5];
        logic [7:0] d3       [3];
        checks   = 0;
        failures = 0;
        sat_data = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0};
        d3       = '{8'h00, 8'h11, 8'h22};

        rst         = 1'b1;
        b4.inData   = 32'hD3C2B1A0;
        b4.inValid  = '0;
        b4.outReady = 1'b0;
        b3.inData   = 24'h221100;
        b3.inValid  = '0;
        b3.outReady = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(b4.outValid), 32'd0);
        check("rst_data",  32'(b4.outData),  32'd0);
        check("rst_sel",   32'(b4.outSel),   32'd0);
        check("rst_ready", 32'(b4.inReady),  32'd0);
        rst = 1'b0;

        // All channels saturated: 0,1,2,3,0
        b4.inValid  = 4'b1111;
        b4.outReady = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("sat_ready", 32'(b4.inReady), 32'(4'b0001 << (i % 4)));
            tick();
            check("sat_valid", 32'(b4.outValid), 32'd1);
            check("sat_data",  32'(b4.outData),  32'(sat_data[i]));
            check("sat_sel",   32'(b4.outSel),   32'(i % 4));
        end

        // Load channel 1, then stall 3 cycles
        tick();
        check("bp_pre_sel", 32'(b4.outSel), 32'd1);
        b4.outReady = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_ready", 32'(b4.inReady), 32'd0);
            tick();
            check("bp_valid", 32'(b4.outValid), 32'd1);
            check("bp_data",  32'(b4.outData),  32'hB1);
            check("bp_sel",   32'(b4.outSel),   32'd1);
        end
        b4.outReady = 1'b1;
        #1;
        check("bp_release_ready", 32'(b4.inReady), 32'b0100);
        tick();
        check("bp_release_sel",  32'(b4.outSel),  32'd2);
        check("bp_release_data", 32'(b4.outData), 32'hC2);

        // Sparse: channel 3 pulses once, then drain
        b4.inValid = 4'b1000;
        #1;
        check("sp_ready", 32'(b4.inReady), 32'b1000);
        tick();
        b4.inValid = 4'b0000;
        check("sp_sel",   32'(b4.outSel),   32'd3);
        check("sp_data",  32'(b4.outData),  32'hD3);
        check("sp_valid", 32'(b4.outValid), 32'd1);
        tick();
        check("drain_valid", 32'(b4.outValid), 32'd0);
        check("drain_sel",   32'(b4.outSel),   32'd3);
        tick();
        check("idle_valid", 32'(b4.outValid), 32'd0);
        b4.inValid = 4'b1001;
        #1;
        check("wrap_ready", 32'(b4.inReady), 32'b0001);
        tick();
        check("wrap_sel", 32'(b4.outSel), 32'd0);

        // Fairness: channel 0 alone, then channel 2 joins and holds
        b4.inValid = 4'b0001;
        tick();
        check("solo0_a", 32'(b4.outSel), 32'd0);
        tick();
        check("solo0_b", 32'(b4.outSel), 32'd0);
        b4.inValid = 4'b0101;
        #1;
        check("fair_ready", 32'(b4.inReady), 32'b0100);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fair_sel", 32'(b4.outSel), (i % 2 == 0) ? 32'd2 : 32'd0);
        end

        // Asynchronous reset mid-transfer with a stalled beat
        b4.outReady = 1'b0;
        b4.inValid  = 4'b0100;
        #2;
        check("mid_pre_valid", 32'(b4.outValid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_valid", 32'(b4.outValid), 32'd0);
        check("mid_data",  32'(b4.outData),  32'd0);
        check("mid_sel",   32'(b4.outSel),   32'd0);
        check("mid_ready", 32'(b4.inReady),  32'd0);
        rst = 1'b0;
        b4.outReady = 1'b1;
        #1;
        check("post_rst_ready", 32'(b4.inReady), 32'b0100);
        tick();
        check("post_rst_sel",  32'(b4.outSel),  32'd2);
        check("post_rst_data", 32'(b4.outData), 32'hC2);

        // Non-power-of-two: n=3 all valid, 0,1,2,0,1
        b4.inValid  = '0;
        b3.inValid  = 3'b111;
        b3.outReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("n3_valid", 32'(b3.outValid), 32'd1);
            check("n3_sel",   32'(b3.outSel),   32'(i % 3));
            check("n3_data",  32'(b3.outData),  32'(d3[i % 3]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
